// File: rtl/yutorina_fetch_stage_if.sv
// Instruction-memory request/grant/valid channel between the fetch stage and imem.
interface yutorina_fetch_stage_if #(
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned INSN_WIDTH = 32
) ();
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [INSN_WIDTH-1:0] imem_rdata;

  // Fetch stage side.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  // Instruction memory side.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/yutorina_fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem request outstanding, and
// presents {if_pc, if_insn, if_valid} downstream through a one-entry skid buffer.
module yutorina_fetch_stage #(
  parameter int unsigned           ADDR_WIDTH = 30,
  parameter int unsigned           INSN_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  yutorina_fetch_stage_if.master imem,
  output logic                  if_valid,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [INSN_WIDTH-1:0] if_insn
);

  typedef enum logic [1:0] {StFetch, StWait, StDrop} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic [ADDR_WIDTH-1:0] req_pc_q;
  logic                  if_valid_q;
  logic [ADDR_WIDTH-1:0] if_pc_q;
  logic [INSN_WIDTH-1:0] if_insn_q;
  logic                  skid_valid_q;
  logic [ADDR_WIDTH-1:0] skid_pc_q;
  logic [INSN_WIDTH-1:0] skid_insn_q;

  logic grant;
  logic resp;
  logic consume;

  assign grant   = imem.imem_req && imem.imem_gnt;
  // A response in WAIT is kept; one in DROP (or coinciding with flush) is discarded.
  assign resp    = (state_q == StWait) && imem.imem_rvalid;
  assign consume = if_valid_q && !stall;

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_insn  = if_insn_q;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: if (grant) state_d = StWait;
      StWait: begin
        if (imem.imem_rvalid) begin
          state_d = StFetch;
        end else if (flush) begin
          state_d = StDrop;
        end
      end
      StDrop:  if (imem.imem_rvalid) state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  // FSM outputs: request only when idle, skid empty and not being redirected.
  always_comb begin
    imem.imem_req  = (state_q == StFetch) && !skid_valid_q && !flush;
    imem.imem_addr = fetch_pc_q;
  end

  // Program counter and address of the outstanding request.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else if (flush) begin
      fetch_pc_q <= flush_pc;
    end else if (grant) begin
      req_pc_q   <= fetch_pc_q;
      fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(1);
    end
  end

  // Output register and skid buffer; a response can never meet a full skid
  // because the skid blocks new requests.
  always_ff @(posedge clock) begin
    if (reset) begin
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_insn_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_insn_q  <= '0;
    end else if (flush) begin
      if_valid_q   <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (resp) begin
      if (!if_valid_q || !stall) begin
        if_valid_q <= 1'b1;
        if_pc_q    <= req_pc_q;
        if_insn_q  <= imem.imem_rdata;
      end else begin
        skid_valid_q <= 1'b1;
        skid_pc_q    <= req_pc_q;
        skid_insn_q  <= imem.imem_rdata;
      end
    end else if (consume) begin
      if (skid_valid_q) begin
        if_pc_q      <= skid_pc_q;
        if_insn_q    <= skid_insn_q;
        skid_valid_q <= 1'b0;
      end else begin
        if_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_yutorina_fetch_stage.sv
// Randomized bench for yutorina_fetch_stage: a behavioural memory plus an
// in-order instruction-stream model checked every cycle.
module tb_yutorina_fetch_stage;
  localparam int unsigned    AW       = 30;
  localparam int unsigned    IW       = 32;
  localparam logic [AW-1:0]  RESET_PC = 30'h100;

  logic          clock;
  logic          reset;
  logic          stall;
  logic          flush;
  logic [AW-1:0] flush_pc;
  logic          if_valid;
  logic [AW-1:0] if_pc;
  logic [IW-1:0] if_insn;

  yutorina_fetch_stage_if #(.ADDR_WIDTH(AW), .INSN_WIDTH(IW)) bus ();

  yutorina_fetch_stage #(
    .ADDR_WIDTH(AW),
    .INSN_WIDTH(IW),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .stall   (stall),
    .flush   (flush),
    .flush_pc(flush_pc),
    .imem    (bus),
    .if_valid(if_valid),
    .if_pc   (if_pc),
    .if_insn (if_insn)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: at most one pending response.
  bit            pend_valid;
  bit            pend_stale;
  int            pend_cnt;
  logic [AW-1:0] pend_addr;
  int            max_lat;
  // Stream model: instructions held by the DUT, next expected pc and fetch address.
  int            held;
  logic [AW-1:0] exp_pc;
  logic [AW-1:0] next_fetch;
  int            n_consumed;
  bit            just_reset;
  bit            last_valid;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'h1000_0000 + IW'(a);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset           = 1'b1;
    stall           = 1'b0;
    flush           = 1'b0;
    flush_pc        = '0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    repeat (2) @(posedge clock);
    pend_valid = 1'b0;
    pend_stale = 1'b0;
    held       = 0;
    exp_pc     = RESET_PC;
    next_fetch = RESET_PC;
    just_reset = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs, advance the models.
  task automatic step(input bit st, input bit fl, input logic [AW-1:0] fpc, input bit g);
    bit            rv;
    bit            req;
    bit            consume;
    logic [AW-1:0] addr;
    @(negedge clock);
    reset           = 1'b0;
    rv              = pend_valid && (pend_cnt == 0);
    stall           = st;
    flush           = fl;
    flush_pc        = fpc;
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? mem_word(pend_addr) : IW'($urandom());
    #1;
    req        = bus.imem_req;
    addr       = bus.imem_addr;
    last_valid = if_valid;

    if (just_reset) begin
      check_eq("reset_if_pc", 64'(if_pc), 64'd0);
      check_eq("reset_if_insn", 64'(if_insn), 64'd0);
      just_reset = 1'b0;
    end
    check_eq("if_valid", 64'(if_valid), 64'(held != 0));
    check_eq("imem_req", 64'(req), 64'(!pend_valid && !fl && held < 2));
    if (req) check_eq("imem_addr", 64'(addr), 64'(next_fetch));
    if (if_valid) begin
      check_eq("if_pc", 64'(if_pc), 64'(exp_pc));
      check_eq("if_insn", 64'(if_insn), 64'(mem_word(exp_pc)));
    end

    consume = if_valid && !st && !fl;
    if (fl) begin
      held       = 0;
      exp_pc     = fpc;
      next_fetch = fpc;
      if (pend_valid) pend_stale = 1'b1;
    end else begin
      if (consume) begin
        held--;
        exp_pc = exp_pc + AW'(1);
        n_consumed++;
      end
      if (rv && !pend_stale) held++;
    end
    if (rv) pend_valid = 1'b0;
    else if (pend_valid) pend_cnt--;
    if (req && g) begin
      pend_valid = 1'b1;
      pend_stale = 1'b0;
      pend_addr  = addr;
      pend_cnt   = $urandom_range(max_lat, 0);
      next_fetch = addr + AW'(1);
    end
  endtask

  initial begin
    int guard;
    int start;
    n_consumed = 0;
    max_lat    = 0;

    // Full-speed memory: if_valid pulses every other cycle starting two cycles after the request.
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      check_eq($sformatf("valid_pulse_%0d", k), 64'(last_valid), 64'(k >= 2 && k % 2 == 0));
    end

    // Grant withheld: request and address must hold.
    repeat (3) step(1'b0, 1'b0, '0, 1'b0);
    repeat (4) step(1'b0, 1'b0, '0, 1'b1);

    // Long stall with responses in flight fills the skid, then drains in order.
    repeat (6) step(1'b1, 1'b0, '0, 1'b1);
    repeat (10) step(1'b0, 1'b0, '0, 1'b1);

    // Flush while waiting on a slow response.
    max_lat = 2;
    guard   = 0;
    while (!(pend_valid && pend_cnt > 0) && guard < 20) begin
      step(1'b0, 1'b0, '0, 1'b1);
      guard++;
    end
    check_eq("reach_wait", 64'(pend_valid && pend_cnt > 0), 64'd1);
    step(1'b0, 1'b1, 30'h40, 1'b1);
    repeat (10) step(1'b0, 1'b0, '0, 1'b1);

    // Flush coinciding with a response while the output is stalled.
    max_lat = 1;
    guard   = 0;
    while (!(held == 1 && pend_valid && pend_cnt == 0) && guard < 30) begin
      step(1'b1, 1'b0, '0, 1'b1);
      guard++;
    end
    check_eq("reach_stalled_resp", 64'(held == 1 && pend_valid && pend_cnt == 0), 64'd1);
    step(1'b1, 1'b1, 30'h80, 1'b1);
    repeat (8) step(1'b0, 1'b0, '0, 1'b1);

    // Address wrap at the top of the word-address space.
    max_lat = 0;
    step(1'b0, 1'b1, '1, 1'b0);
    repeat (8) step(1'b0, 1'b0, '0, 1'b1);

    // Reset in the middle of a WAIT.
    max_lat = 3;
    guard   = 0;
    while (!pend_valid && guard < 20) begin
      step(1'b0, 1'b0, '0, 1'b1);
      guard++;
    end
    check_eq("reach_wait_for_reset", 64'(pend_valid), 64'd1);
    apply_reset();
    repeat (4) step(1'b0, 1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] fpc;
      fpc = ($urandom_range(3, 0) == 0) ? ('1 - AW'($urandom_range(3, 0))) : AW'($urandom());
      if ($urandom_range(999, 0) < 2) apply_reset();
      step($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 3, fpc,
           $urandom_range(99, 0) < 60);
    end

    // Drain with no stalls: the stream must keep moving.
    start = n_consumed;
    repeat (300) step(1'b0, 1'b0, '0, 1'b1);
    check_eq("drain_progress", 64'((n_consumed - start) >= 40), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
